wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline write-back path and the long-latency modular-arithmetic coprocessor used for RSA decryption. Coprocessor results are queued in a small FIFO and drained into idle write-back slots. A starvation counter requests a pipeline bubble when queued results are blocked for too long. The block sits between the write-back stage output, the coprocessor result port and the register file write port, and gives the hazard unit a pending-write lookup.

---
 rtl/wb_port_arbiter_if.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port arbitration bundle: pipeline write-back, coprocessor
// result handshake, register-file write port and hazard-unit lookup.
interface wb_port_arbiter_if #(
  parameter int N     = 32,
  parameter int A     = 4,
  parameter int DEPTH = 4
);
  logic                     pipe_we;
  logic [A-1:0]             pipe_rd;
  logic [N-1:0]             pipe_data;

  logic                     cop_valid;
  logic [A-1:0]             cop_rd;
  logic [N-1:0]             cop_data;
  logic                     cop_ready;

  logic                     rf_we;
  logic [A-1:0]             rf_wa;
  logic [N-1:0]             rf_wd;

  logic                     hold;
  logic [A-1:0]             query_rd;
  logic                     query_hit;
  logic [$clog2(DEPTH):0]   pend_count;

  // Environment side: pipeline, coprocessor, register file and hazard unit.
  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output cop_valid, cop_rd, cop_data,
    input  cop_ready,
    input  rf_we, rf_wa, rf_wd,
    input  hold,
    output query_rd,
    input  query_hit, pend_count
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  cop_valid, cop_rd, cop_data,
    output cop_ready,
    output rf_we, rf_wa, rf_wd,
    output hold,
    input  query_rd,
    output query_hit, pend_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order write-back
// path and the modular-arithmetic coprocessor. Coprocessor results wait in a
// small circular FIFO and drain into cycles where the pipeline does not write;
// a saturating starvation counter asks the hazard unit for a bubble when the
// head entry has been blocked too long.
module wb_port_arbiter #(
  parameter int N          = 32,
  parameter int A          = 4,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
)(
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [A-1:0]  rdMem_q   [DEPTH];
  logic [N-1:0]  dataMem_q [DEPTH];

  logic [PW-1:0] rdPtr_q,  rdPtr_d;
  logic [PW-1:0] wrPtr_q,  wrPtr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          notFull;
  logic          hasEntry;
  logic          push;
  logic          pop;
  logic          queryHit;

  assign notFull  = (count_q < CW'(DEPTH));
  assign hasEntry = (count_q != '0);

  // A full FIFO refuses results even when it pops this cycle, and nothing is
  // accepted while reset is held.
  assign bus.cop_ready = notFull & ~rst;
  assign push          = bus.cop_valid & notFull & ~rst;
  assign pop           = ~rst & ~bus.pipe_we & hasEntry;

  assign bus.pend_count = count_q;
  assign bus.hold       = (starve_q == SW'(STARVE_MAX)) & hasEntry;
  assign bus.query_hit  = queryHit;

  // Write-port grant: pipeline first, then FIFO head, otherwise an idle port.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    if (!rst) begin
      if (bus.pipe_we) begin
        bus.rf_we = 1'b1;
        bus.rf_wa = bus.pipe_rd;
        bus.rf_wd = bus.pipe_data;
      end else if (hasEntry) begin
        bus.rf_we = 1'b1;
        bus.rf_wa = rdMem_q[rdPtr_q];
        bus.rf_wd = dataMem_q[rdPtr_q];
      end
    end
  end

  // Next FIFO pointers, occupancy and starvation count from this cycle's push/pop.
  always_comb begin
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      starve_d = '0;
    end else if (hasEntry && bus.pipe_we && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Control state register with synchronous reset that discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Entry storage; only slots inside the occupied window are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem_q[wrPtr_q]   <= bus.cop_rd;
      dataMem_q[wrPtr_q] <= bus.cop_data;
    end
  end

  // Pending-write lookup over occupied slots, using registered state only.
  always_comb begin
    logic [PW-1:0] offset;
    queryHit = 1'b0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rdPtr_q;
      if (({1'b0, offset} < count_q) && (rdMem_q[i] == bus.query_rd)) begin
        queryHit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter, checked every cycle
// against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int N          = 32;
  localparam int A          = 4;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  typedef struct packed {
    logic [A-1:0] rd;
    logic [N-1:0] data;
  } entry_t;

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.N(N), .A(A), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(
    .N(N), .A(A), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  entry_t modelQ[$];
  int     modelStarve;
  int     checkCount;
  int     errorCount;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic pwe, input logic [A-1:0] prd,
                               input logic [N-1:0] pdata, input logic cv,
                               input logic [A-1:0] crd, input logic [N-1:0] cdata,
                               input logic [A-1:0] qrd);
    rst           = r;
    bus.pipe_we   = pwe;
    bus.pipe_rd   = prd;
    bus.pipe_data = pdata;
    bus.cop_valid = cv;
    bus.cop_rd    = crd;
    bus.cop_data  = cdata;
    bus.query_rd  = qrd;
  endtask

  // Compare every output with what the model's current contents imply.
  task automatic checkCycle();
    logic         expWe;
    logic [A-1:0] expWa;
    logic [N-1:0] expWd;
    logic         expHit;
    int           sz;
    sz     = modelQ.size();
    expWe  = 1'b0;
    expWa  = '0;
    expWd  = '0;
    expHit = 1'b0;
    if (!rst) begin
      if (bus.pipe_we) begin
        expWe = 1'b1;
        expWa = bus.pipe_rd;
        expWd = bus.pipe_data;
      end else if (sz > 0) begin
        expWe = 1'b1;
        expWa = modelQ[0].rd;
        expWd = modelQ[0].data;
      end
    end
    foreach (modelQ[i]) begin
      if (modelQ[i].rd == bus.query_rd) expHit = 1'b1;
    end
    checkOutput("rf_we",      32'(bus.rf_we),      32'(expWe));
    checkOutput("rf_wa",      32'(bus.rf_wa),      32'(expWa));
    checkOutput("rf_wd",      bus.rf_wd,           expWd);
    checkOutput("cop_ready",  32'(bus.cop_ready),  32'((sz < DEPTH) && !rst));
    checkOutput("pend_count", 32'(bus.pend_count), 32'(sz));
    checkOutput("hold",       32'(bus.hold),       32'((modelStarve == STARVE_MAX) && (sz > 0)));
    checkOutput("query_hit",  32'(bus.query_hit),  32'(expHit));
  endtask

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic updateModel();
    int  sz;
    bit  doPop;
    bit  doPush;
    sz = modelQ.size();
    if (rst) begin
      modelQ.delete();
      modelStarve = 0;
    end else begin
      doPop  = !bus.pipe_we && (sz > 0);
      doPush = bus.cop_valid && (sz < DEPTH);
      if (doPop) begin
        void'(modelQ.pop_front());
        modelStarve = 0;
      end else if ((sz > 0) && bus.pipe_we) begin
        modelStarve = (modelStarve + 1 > STARVE_MAX) ? STARVE_MAX : modelStarve + 1;
      end
      if (doPush) modelQ.push_back('{rd: bus.cop_rd, data: bus.cop_data});
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic runCycle(input logic r, input logic pwe, input logic [A-1:0] prd,
                          input logic [N-1:0] pdata, input logic cv,
                          input logic [A-1:0] crd, input logic [N-1:0] cdata,
                          input logic [A-1:0] qrd);
    applyStimulus(r, pwe, prd, pdata, cv, crd, cdata, qrd);
    stepCycle();
  endtask

  initial begin
    int pct;
    checkCount  = 0;
    errorCount  = 0;
    modelStarve = 0;

    applyStimulus(1'b1, 1'b1, 4'd1, 32'h1111, 1'b0, 4'd0, 32'h0, 4'd0);
    @(posedge clk);
    #1;

    // Reset held with pipeline writing, then idle behaviour.
    runCycle(1'b1, 1'b1, 4'd1, 32'h1111, 1'b0, 4'd0, 32'h0, 4'd0);
    runCycle(1'b1, 1'b1, 4'd1, 32'h1111, 1'b0, 4'd0, 32'h0, 4'd0);
    runCycle(1'b0, 1'b1, 4'd6, 32'hABCD, 1'b0, 4'd0, 32'h0, 4'd6);
    runCycle(1'b0, 1'b0, 4'd6, 32'hABCD, 1'b0, 4'd0, 32'h0, 4'd6);

    // Drain on idle.
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'hDEADBEEF, 4'd3);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd3);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd3);

    // Pipeline priority over a queued entry.
    runCycle(1'b0, 1'b1, 4'd9, 32'h22, 1'b1, 4'd7, 32'h77, 4'd7);
    runCycle(1'b0, 1'b1, 4'd5, 32'h11, 1'b0, 4'd0, 32'h0, 4'd7);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd7);

    // Fill past capacity, drain, refill across the wrap, drain with pushes.
    for (int i = 0; i < 5; i++)
      runCycle(1'b0, 1'b1, 4'(i + 1), 32'h100 + i, 1'b1, 4'(8 + i), 32'hC000_0000 + i, 4'd12);
    for (int i = 0; i < 4; i++)
      runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd12);
    for (int i = 0; i < 3; i++)
      runCycle(1'b0, 1'b1, 4'd1, 32'h200 + i, 1'b1, 4'(i), 32'hD000_0000 + i, 4'd1);
    for (int i = 0; i < 5; i++)
      runCycle(1'b0, 1'b0, 4'd0, 32'h0, i < 2, 4'(13 + i), 32'hE000_0000 + i, 4'd13);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd0);

    // Starvation: one entry blocked for STARVE_MAX edges, then released.
    runCycle(1'b0, 1'b1, 4'd4, 32'h44, 1'b1, 4'd10, 32'hAAAA, 4'd10);
    for (int i = 0; i < STARVE_MAX + 1; i++)
      runCycle(1'b0, 1'b1, 4'd4, 32'h44 + i, 1'b0, 4'd0, 32'h0, 4'd10);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd10);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd10);

    // Lookup, then reset discards the queued entries.
    runCycle(1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2222, 4'd9);
    runCycle(1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd9, 32'h9999, 4'd9);
    runCycle(1'b0, 1'b1, 4'd1, 32'h1, 1'b0, 4'd0, 32'h0, 4'd9);
    runCycle(1'b0, 1'b1, 4'd1, 32'h1, 1'b0, 4'd0, 32'h0, 4'd4);
    runCycle(1'b1, 1'b1, 4'd1, 32'h1, 1'b0, 4'd0, 32'h0, 4'd9);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd9);
    runCycle(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd2);

    // Random traffic with pipeline load varied to reach starvation and drain.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       pct = 30;
        1:       pct = 75;
        default: pct = 96;
      endcase
      runCycle($urandom_range(0, 99) < 1,
               $urandom_range(0, 99) < pct,
               4'($urandom), $urandom,
               $urandom_range(0, 99) < 60,
               4'($urandom), $urandom,
               4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule
